// File: rtl/burst_bus_master.sv
// burst_bus_master
//   Bus master for the shared system bus. User commands are queued in a small
//   FIFO; each command requests the bus and runs a 1..BURST_MAX beat read or
//   write burst with an auto-incrementing address. The bus is held for the
//   whole burst.
//
//   Optional feature macro: BBM_TIMEOUT_EN
//     defined   : a beat that sees no ready for TIMEOUT_CYC cycles aborts the
//                 burst (remaining beats dropped) and pulses o_u_err.
//     undefined : the master waits for ready indefinitely, o_u_err is 0.
//
//   Ports
//     i_clk, i_rst            clock (rising edge), async active-high reset
//     o_breq / i_bgrant       bus request to / grant from the arbiter
//     o_mode                  1 = write, 0 = read
//     o_addr, o_wdata         beat address and write data
//     i_rdata                 read data from slave
//     o_valid / i_ready       beat handshake with the slave
//     i_u_addr/mode/len       command: start address, mode, beats-1
//     i_u_start               push command (taken only when o_u_cmd_ready)
//     o_u_cmd_ready           command FIFO not full
//     i_u_wdata / o_u_wready  write data stream; advance when o_u_wready
//     o_u_rdata / o_u_rvalid  last read beat, one-cycle pulse when new
//     o_u_busy                FIFO non-empty or FSM not idle
//     o_u_err                 one-cycle pulse, burst aborted
//     o_state_show            IDLE=0 REQ=1 ADDR=2 WRITE=3 READ=4
//
//   state | meaning
//   IDLE  | waiting for a queued command; pops it when present
//   REQ   | breq high, waiting for grant
//   ADDR  | grant seen; first write data captured, valid rises after edge
//   WRITE | write beats in progress
//   READ  | read beats in progress
module burst_bus_master #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int BURST_MAX   = 8,
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 15,
   localparam int LEN_W      = $clog2(BURST_MAX)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_breq,
   input  logic              i_bgrant,
   output logic              o_mode,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   output logic              o_valid,
   input  logic              i_ready,
   input  logic [ADDR_W-1:0] i_u_addr,
   input  logic              i_u_mode,
   input  logic [LEN_W-1:0]  i_u_len,
   input  logic              i_u_start,
   output logic              o_u_cmd_ready,
   input  logic [DATA_W-1:0] i_u_wdata,
   output logic              o_u_wready,
   output logic [DATA_W-1:0] o_u_rdata,
   output logic              o_u_rvalid,
   output logic              o_u_busy,
   output logic              o_u_err,
   output logic [2:0]        o_state_show
);
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CMD_W = 1 + LEN_W + ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_ADDR  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_breq;
   logic                r_valid;
   logic                r_mode;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [LEN_W-1:0]    r_beats_left;
   logic [DATA_W-1:0]   r_u_rdata;
   logic                r_u_rvalid;

   logic [CMD_W-1:0]    r_fifo [CMD_DEPTH];
   logic [PTR_W:0]      r_wr_ptr;
   logic [PTR_W:0]      r_rd_ptr;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [CMD_W-1:0]    w_head;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   // A push while full is dropped even if the FSM pops on the same edge.
   assign w_push  = i_u_start && !w_full;
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   assign w_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= {i_u_mode, i_u_len, i_u_addr};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

`ifdef BBM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            r_u_err;
   assign o_u_err = r_u_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign o_u_err = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_breq       <= 1'b0;
         r_valid      <= 1'b0;
         r_mode       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_beats_left <= '0;
         r_u_rdata    <= '0;
         r_u_rvalid   <= 1'b0;
`ifdef BBM_TIMEOUT_EN
         r_to_cnt     <= '0;
         r_u_err      <= 1'b0;
`endif
      end else begin
         r_u_rvalid <= 1'b0;
`ifdef BBM_TIMEOUT_EN
         r_u_err    <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  {r_mode, r_beats_left, r_addr} <= w_head;
                  r_breq  <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_bgrant) r_state <= S_ADDR;
            end
            S_ADDR: begin
               if (r_mode) r_wdata <= i_u_wdata;
               r_valid <= 1'b1;
               r_state <= r_mode ? S_WRITE : S_READ;
`ifdef BBM_TIMEOUT_EN
               r_to_cnt <= TO_LOAD;
`endif
            end
            S_WRITE, S_READ: begin
               if (i_ready) begin
                  if (r_state == S_READ) begin
                     r_u_rdata  <= i_rdata;
                     r_u_rvalid <= 1'b1;
                  end
                  if (r_beats_left != '0) begin
                     r_addr       <= r_addr + ADDR_W'(1);
                     r_beats_left <= r_beats_left - LEN_W'(1);
                     if (r_state == S_WRITE) r_wdata <= i_u_wdata;
`ifdef BBM_TIMEOUT_EN
                     r_to_cnt <= TO_LOAD;
`endif
                  end else begin
                     r_breq  <= 1'b0;
                     r_valid <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
`ifdef BBM_TIMEOUT_EN
               else if (r_to_cnt == '0) begin
                  r_breq  <= 1'b0;
                  r_valid <= 1'b0;
                  r_u_err <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt - TO_W'(1);
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write data is taken on the ADDR edge and on every non-final write beat.
   assign o_u_wready = ((r_state == S_ADDR) && r_mode) ||
                       ((r_state == S_WRITE) && i_ready && (r_beats_left != '0));

   assign o_breq        = r_breq;
   assign o_valid       = r_valid;
   assign o_mode        = r_mode;
   assign o_addr        = r_addr;
   assign o_wdata       = r_wdata;
   assign o_u_rdata     = r_u_rdata;
   assign o_u_rvalid    = r_u_rvalid;
   assign o_u_cmd_ready = !w_full;
   assign o_u_busy      = !w_empty || (r_state != S_IDLE);
   assign o_state_show  = r_state;
endmodule
